// File: rtl/fifo_packer.sv
// Drains DWIDTH-bit FIFO entries and packs RATIO of them into one wide word on a valid/ready port.
// Optional macro PACKER_TIMEOUT_EN flushes a partial word after TIMEOUT idle cycles.
module fifo_packer #(
    parameter int DWIDTH  = 4,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [DWIDTH-1:0]            fifo_data,
    output logic                         fifo_read_en,
    output logic [DWIDTH*RATIO-1:0]      out_data,
    output logic [$clog2(RATIO+1)-1:0]   out_count,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CW = $clog2(RATIO+1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           issued_q, issued_d;
    logic [CW-1:0]           captured_q, captured_d;
    logic                    pending_q, pending_d;
    logic [DWIDTH*RATIO-1:0] data_q, data_d;

`ifdef PACKER_TIMEOUT_EN
    logic [7:0]              idle_q, idle_d;
`else
    logic                    unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    // In-flight reads count against issued, so a word never over-reads the FIFO.
    assign fifo_read_en = (state_q == FILL) && !fifo_empty && !rst && (issued_q < CW'(RATIO));

    assign out_valid = (state_q == HOLD);
    assign out_count = captured_q;
    assign out_data  = data_q;

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        captured_d = captured_q;
        pending_d  = 1'b0;
        data_d     = data_q;
`ifdef PACKER_TIMEOUT_EN
        idle_d     = '0;
`endif
        case (state_q)
            FILL: begin
                pending_d = fifo_read_en;
                if (fifo_read_en) begin
                    issued_d = issued_q + CW'(1);
                end
                if (pending_q) begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (captured_q == CW'(i)) begin
                            data_d[i*DWIDTH +: DWIDTH] = fifo_data;
                        end
                    end
                    captured_d = captured_q + CW'(1);
                    if (captured_d == CW'(RATIO)) begin
                        state_d = HOLD;
                    end
                end
`ifdef PACKER_TIMEOUT_EN
                // Idle means a partial word with nothing in flight and nothing to read.
                if ((captured_q != '0) && (issued_q == captured_q) && fifo_empty) begin
                    idle_d = idle_q + 8'd1;
                    if (idle_d == 8'(TIMEOUT)) begin
                        state_d = HOLD;
                    end
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = FILL;
                    issued_d   = '0;
                    captured_d = '0;
                    data_d     = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            issued_q   <= '0;
            captured_q <= '0;
            pending_q  <= 1'b0;
            data_q     <= '0;
`ifdef PACKER_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            captured_q <= captured_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
`ifdef PACKER_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

endmodule

// File: doc/fifo_packer.md
# fifo_packer

Downstream consumer of the nibble FIFO. It drains `DWIDTH`-bit entries through the FIFO's `read_en`/`empty`/`data_out` port and packs `RATIO` consecutive entries into one wide word. The word is presented on a valid/ready output handshake. It sits between the FIFO read side and any wide-datapath sink, and shares the FIFO's clock and reset.

## Interface
- `DWIDTH`, 4, FIFO entry width; must equal the FIFO's `DWIDTH`.
- `RATIO`, 4, FIFO entries per output word; range 2..16.
- `TIMEOUT`, 8, idle cycles before a partial word is flushed. Used only when `PACKER_TIMEOUT_EN` is defined. Range 1..255.
- `clk  in  1  single clock; all logic on posedge.`
- `rst  in  1  synchronous, active-high reset.`
- `fifo_empty  in  1  FIFO empty flag.`
- `fifo_data  in  DWIDTH  FIFO data_out; valid the cycle after a read_en cycle.`
- `fifo_read_en  out  1  read request to FIFO; combinational.`
- `out_data  out  DWIDTH*RATIO  packed word; first entry in bits [DWIDTH-1:0].`
- `out_count  out  $clog2(RATIO+1)  number of valid entries in out_data.`
- `out_valid  out  1  word available.`
- `out_ready  in  1  sink accepts word.`

## Operation
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- State is held in two counters, `issued` and `captured`, each 0..RATIO, plus a 1-bit `pending` flag meaning "read issued last cycle".
- FSM states:
  - FILL (reset state).
    - `fifo_read_en = !fifo_empty && !rst && (issued < RATIO)`.
    - Each cycle with `fifo_read_en` high increments `issued` and sets `pending` for the next cycle.
    - When `pending` is high, `fifo_data` is written into slot `captured` and `captured` increments.
    - When the capture brings `captured` to RATIO, go to HOLD at the same edge: `out_valid` goes to 1 and `out_count` = RATIO.
  - HOLD.
    - `fifo_read_en` = 0.
    - `out_data`, `out_count` and `out_valid` stay stable until `out_valid && out_ready` is sampled at a posedge.
    - At that edge: clear the counters and all slots to 0, drop `out_valid`, and return to FILL.
- Back-to-back reads are permitted. The FIFO can be read every cycle while non-empty, and in-flight reads count against `issued`, so reads never exceed RATIO per word.
- Slots not yet captured read as 0 in `out_data`.
- Simultaneous events:
  - A FIFO write in the same cycle as `fifo_read_en` is the FIFO's concern. The packer only obeys `fifo_empty` as sampled that cycle.
  - `out_ready` high while `out_valid` is low has no effect.
- Reset asserted mid-word:
  - Partial slots, counters and `pending` are cleared, and the state returns to FILL.
  - An entry in flight is discarded.
  - `fifo_read_en` is forced to 0 during reset.
- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0, `fifo_read_en`=0.

## Timing
- First `fifo_read_en` in cycle t with an uninterrupted non-empty FIFO:
  - Reads occur in cycles t..t+RATIO-1.
  - Captures occur at the edges ending t+1..t+RATIO.
  - `out_valid` is high from cycle t+RATIO+1.
  - Latency is RATIO+1 cycles.
- Handshake at the edge ending cycle h: `out_valid` is low in h+1, and `fifo_read_en` may assert in h+1.
- Sustained throughput is one word per RATIO+2 cycles when `out_ready` is held high.
- Gaps in FIFO availability only stretch FILL. Entry order is preserved.

## Configuration
- Macro: `PACKER_TIMEOUT_EN`.
- Defined:
  - An 8-bit idle counter counts cycles in FILL with `captured>0`, `issued==captured` and `fifo_empty`=1.
  - It resets on any read and holds 0 when `captured==0`.
  - On reaching TIMEOUT, go to HOLD with `out_count=captured`; unused slots are 0.
- Not defined: no idle counter. Words are emitted only when full, and `out_count` is always RATIO when `out_valid` is high.

## Test plan
- Reset: assert `rst` for 2 cycles with the FIFO holding data -> `fifo_read_en`=0 and all outputs 0 throughout.
- Streaming: write entries 1..8 into the FIFO with `out_ready`=1 -> words 0x4321 then 0x8765, `out_count`=4, and `fifo_read_en` high for 4 consecutive cycles per word.
- Backpressure: complete word 0xDCBA and hold `out_ready`=0 for 10 cycles -> `out_valid` stays 1, `out_data` stays 0xDCBA, `fifo_read_en` stays 0, and FIFO occupancy is unchanged.
- Starvation: entries 5,6,7,8 written one every 3 cycles -> a single word 0x8765 with no duplicate or skipped entries.
- Timeout (macro on, TIMEOUT=8): write A,B,C then stop -> after 8 idle cycles, `out_data`=0x0CBA and `out_count`=3. With the macro off, no `out_valid` ever rises.
- Mid-word reset: pulse `rst` after 2 captures, then write 1..4 -> the next word is 0x4321 with nothing stale in it.
